// File: rtl/axis_slave_adc_avg.sv
// axis_slave_adc_avg
//   AXI4-Stream slave that averages each 2^LOG2_LEN-beat ADC packet into a
//   single 14-bit result and re-emits it on an AXI4-Stream master port. The
//   master side is framed by m_axis_tlast every OUT_PKT_LEN results. Input
//   framing is checked; bad packets are dropped and counted.
//
// Ports
//   axis_aclk, axis_aresetn    clock, async active-low reset
//   s_axis_*                   input sample stream (tdata[13:0] used)
//   m_axis_*                   averaged result stream {2'b00, avg[13:0]}
//   pkt_count                  good packets averaged (wraps)
//   err_count                  framing errors (saturates)
module axis_slave_adc_avg #(
    parameter int LOG2_LEN    = 6,
    parameter int OUT_PKT_LEN = 16,
    parameter int ERR_W       = 8
) (
    input  logic             axis_aclk,
    input  logic             axis_aresetn,
    input  logic [15:0]      s_axis_tdata,
    input  logic [1:0]       s_axis_tstrb,
    input  logic [1:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [15:0]      m_axis_tdata,
    output logic [1:0]       m_axis_tstrb,
    output logic [1:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [15:0]      pkt_count,
    output logic [ERR_W-1:0] err_count
);

    localparam int ACC_W  = 14 + LOG2_LEN;
    localparam int OCNT_W = (OUT_PKT_LEN > 1) ? $clog2(OUT_PKT_LEN) : 1;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_RESYNC = 2'd2;

    logic [1:0]          state;
    logic [ACC_W-1:0]    acc;
    logic [LOG2_LEN-1:0] beat_cnt;
    logic [OCNT_W-1:0]   out_cnt;
    logic [OCNT_W-1:0]   out_cnt_nxt;
    logic [ACC_W-1:0]    sum;
    logic                accept;
    logic                m_hs;
    logic                last_beat;
    logic                err_inc;

    // Strobes/keep and the two spare ADC bits carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tstrb, s_axis_tkeep, s_axis_tdata[15:14]};

    assign m_axis_tstrb = 2'b11;
    assign m_axis_tkeep = 2'b11;

    // Single-entry output register: input may only be taken when that
    // register is empty or draining this cycle, so a finishing packet can
    // always be loaded.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            ST_ACCUM:  s_axis_tready = !m_axis_tvalid || m_axis_tready;
            ST_RESYNC: s_axis_tready = 1'b1;
            default:   s_axis_tready = 1'b0;
        endcase
    end

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign m_hs      = m_axis_tvalid && m_axis_tready;
    assign last_beat = &beat_cnt;
    assign sum       = acc + ACC_W'(s_axis_tdata[13:0]);

    // Early tlast and missing tlast are both a mismatch between tlast and
    // the final beat position.
    assign err_inc = (state == ST_ACCUM) && accept && (s_axis_tlast ^ last_beat);

    // Counter value the next loaded result will carry; accounts for a drain
    // happening on the same edge as the load.
    always_comb begin
        out_cnt_nxt = out_cnt;
        if (m_hs)
            out_cnt_nxt = (out_cnt == OCNT_W'(OUT_PKT_LEN - 1)) ? '0 : out_cnt + 1'b1;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state         <= ST_INIT;
            acc           <= '0;
            beat_cnt      <= '0;
            out_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            pkt_count     <= '0;
            err_count     <= '0;
        end else begin
            out_cnt <= out_cnt_nxt;
            if (m_hs)
                m_axis_tvalid <= 1'b0;
            if (err_inc && err_count != '1)
                err_count <= err_count + 1'b1;

            case (state)
                ST_INIT: state <= ST_ACCUM;
                ST_ACCUM: begin
                    if (accept) begin
                        if (s_axis_tlast || last_beat) begin
                            acc      <= '0;
                            beat_cnt <= '0;
                            if (s_axis_tlast && last_beat) begin
                                // Truncating divide by 2^LOG2_LEN.
                                m_axis_tdata  <= {2'b00, sum[ACC_W-1:LOG2_LEN]};
                                m_axis_tvalid <= 1'b1;
                                m_axis_tlast  <= (out_cnt_nxt == OCNT_W'(OUT_PKT_LEN - 1));
                                pkt_count     <= pkt_count + 16'd1;
                            end else if (!s_axis_tlast) begin
                                state <= ST_RESYNC;
                            end
                        end else begin
                            acc      <= sum;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_RESYNC: begin
                    // Discard until the stream's own tlast realigns us.
                    if (accept && s_axis_tlast) begin
                        state    <= ST_ACCUM;
                        acc      <= '0;
                        beat_cnt <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
